// File: rtl/pool_apply_arb.sv
// pool_apply_arb
//   Round-robin arbiter sharing the resource pool's single pool-apply request
//   port between NUM_REQ upstream WQE engines. One request is granted per
//   cycle into a one-entry output register. The register holds its contents
//   until the pool accepts them. Each forwarded request carries the index of
//   the requester that sent it.
//
//   Handshake semantics, on every port: a transfer happens in a cycle where
//   valid and ready are both high at the rising edge. A producer holds valid
//   and its payload stable until the transfer happens. Ready may depend on
//   valid. Valid must never depend on ready.
//
//   Optional feature (compile-time macro POOL_ARB_ZERO_LEN_DROP_EN):
//     defined   - a winning request with len == 0 is accepted but not
//                 forwarded; drop_cnt counts such requests and saturates.
//     undefined - zero-length requests are forwarded like any other request;
//                 drop_cnt is tied to 0.
//
// Ports (W = WQE_INDEX_WIDTH + WQE_SOURCE_LENGTH):
//   sys_clk              in   1         clock, rising edge
//   sys_rst              in   1         synchronous active-high reset
//   s_axis_req_valid     in   NUM_REQ   per-requester valid
//   s_axis_req_id_len    in   NUM_REQ*W slot i at [i*W +: W]: {len, id}
//   s_axis_req_ready     out  NUM_REQ   one-hot or zero, combinational
//   m_axis_Papply_valid  out  1         output valid (registered)
//   m_axis_Papply_id_len out  W         granted {len, id} (registered)
//   m_axis_Papply_src    out  SRC_WIDTH granted requester index (registered)
//   m_axis_Papply_ready  in   1         pool ready
//   drop_cnt             out  16        dropped zero-length request count

module pool_apply_arb #(
    parameter int NUM_REQ           = 4,
    parameter int WQE_INDEX_WIDTH   = 10,
    parameter int WQE_SOURCE_LENGTH = 11,
    parameter int SRC_WIDTH         = $clog2(NUM_REQ)
) (
    input  logic                                                   sys_clk,
    input  logic                                                   sys_rst,
    input  logic [NUM_REQ-1:0]                                     s_axis_req_valid,
    input  logic [NUM_REQ*(WQE_INDEX_WIDTH+WQE_SOURCE_LENGTH)-1:0] s_axis_req_id_len,
    output logic [NUM_REQ-1:0]                                     s_axis_req_ready,
    output logic                                                   m_axis_Papply_valid,
    output logic [WQE_INDEX_WIDTH+WQE_SOURCE_LENGTH-1:0]           m_axis_Papply_id_len,
    output logic [SRC_WIDTH-1:0]                                   m_axis_Papply_src,
    input  logic                                                   m_axis_Papply_ready,
    output logic [15:0]                                            drop_cnt
);

    localparam int W = WQE_INDEX_WIDTH + WQE_SOURCE_LENGTH;

    // Output stage state; valid is simply "stage is FULL".
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t           out_state;
    logic [SRC_WIDTH-1:0] rr_ptr;

    logic                 load;
    logic                 grant;
    logic                 fwd;
    logic                 drop_win;
    logic                 found_hi;
    logic                 found_lo;
    logic [SRC_WIDTH-1:0] win_hi;
    logic [SRC_WIDTH-1:0] win_lo;
    logic [SRC_WIDTH-1:0] win;
    logic [W-1:0]         win_slot;

    assign m_axis_Papply_valid = (out_state == FULL);

    // The stage can take a new request when it is empty or being drained now.
    assign load = !sys_rst && (!m_axis_Papply_valid || m_axis_Papply_ready);

    // Round-robin search without a modulo: the first valid requester at or
    // above rr_ptr wins; if there is none, the search has wrapped and the
    // lowest valid index wins.
    always_comb begin
        found_hi         = 1'b0;
        found_lo         = 1'b0;
        win_hi           = '0;
        win_lo           = '0;
        win_slot         = '0;
        s_axis_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (s_axis_req_valid[k]) begin
                if (!found_hi && (k >= int'(rr_ptr))) begin
                    found_hi = 1'b1;
                    win_hi   = SRC_WIDTH'(k);
                end
                if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = SRC_WIDTH'(k);
                end
            end
        end
        win   = found_hi ? win_hi : win_lo;
        grant = load && found_lo;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == SRC_WIDTH'(k)) begin
                win_slot            = s_axis_req_id_len[k*W +: W];
                s_axis_req_ready[k] = grant;
            end
        end
    end

`ifdef POOL_ARB_ZERO_LEN_DROP_EN
    assign drop_win = (win_slot[W-1:WQE_INDEX_WIDTH] == '0);
`else
    assign drop_win = 1'b0;
`endif

    // A dropped winner is handshaked but behaves like "no grant" for the stage.
    assign fwd = grant && !drop_win;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_state            <= EMPTY;
            m_axis_Papply_id_len <= '0;
            m_axis_Papply_src    <= '0;
            rr_ptr               <= '0;
        end else begin
            if (grant) begin
                rr_ptr <= (win == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (fwd) begin
                out_state            <= FULL;
                m_axis_Papply_id_len <= win_slot;
                m_axis_Papply_src    <= win;
            end else if (m_axis_Papply_ready) begin
                // Consumed with nothing new behind it; data/src keep last values.
                out_state <= EMPTY;
            end
        end
    end

`ifdef POOL_ARB_ZERO_LEN_DROP_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_cnt <= '0;
        end else if (grant && drop_win && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pool_apply_arb.sv
// tb_pool_apply_arb
//   Directed bench for pool_apply_arb (NUM_REQ=4, W=21). A table of
//   single-cycle vectors covers reset, grant order, wrap-around, backpressure
//   and mid-operation reset; hand-written sequences cover the zero-length
//   request case and a long single-requester stream under random pool
//   backpressure checked against an expected queue.

module tb_pool_apply_arb;

  localparam int NREQ = 4;
  localparam int W    = 21;

  logic              sys_clk;
  logic              sys_rst;
  logic [NREQ-1:0]   s_valid;
  logic [NREQ*W-1:0] s_id_len;
  logic [NREQ-1:0]   s_ready;
  logic              m_valid;
  logic [W-1:0]      m_id_len;
  logic [1:0]        m_src;
  logic              m_ready;
  logic [15:0]       drop_cnt;

  int n_vec;
  int n_fail;

  pool_apply_arb dut (
    .sys_clk              (sys_clk),
    .sys_rst              (sys_rst),
    .s_axis_req_valid     (s_valid),
    .s_axis_req_id_len    (s_id_len),
    .s_axis_req_ready     (s_ready),
    .m_axis_Papply_valid  (m_valid),
    .m_axis_Papply_id_len (m_id_len),
    .m_axis_Papply_src    (m_src),
    .m_axis_Papply_ready  (m_ready),
    .drop_cnt             (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] stream_pay(input int n);
    stream_pay = {11'((n % 2047) + 1), 10'(n % 1024)};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic            rst;
    logic [NREQ-1:0] valid;
    logic            mrdy;
    logic [NREQ-1:0] exp_ready;  // combinational, this cycle
    logic            exp_valid;  // after the edge
    logic [W-1:0]    exp_data;
    logic [1:0]      exp_src;
    logic [1:0]      exp_rr;
  } vec_t;

  localparam logic [W-1:0] D0 = {11'd1, 10'd10};
  localparam logic [W-1:0] D1 = {11'd2, 10'd11};
  localparam logic [W-1:0] D2 = {11'd3, 10'd5};
  localparam logic [W-1:0] D3 = {11'd4, 10'd13};

  vec_t vecs[20];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;
  int sent;
  int rcvd;
  int cyc;

  initial begin
    n_vec    = 0;
    n_fail   = 0;
    sys_rst  = 1'b1;
    s_valid  = '0;
    s_id_len = '0;
    m_ready  = 1'b0;

    //            rst   valid    mrdy  exp_rdy  ev    data  src   rr
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 21'd0, 2'd0, 2'd0};
    vecs[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, D2,    2'd2, 2'd3};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, D2,    2'd2, 2'd3};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, D3,    2'd3, 2'd0};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, D0,    2'd0, 2'd1};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, D1,    2'd1, 2'd2};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, D2,    2'd2, 2'd3};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, D3,    2'd3, 2'd0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, D0,    2'd0, 2'd1};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, D1,    2'd1, 2'd2};
    vecs[10] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, D1,    2'd1, 2'd2};
    vecs[11] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, D1,    2'd1, 2'd2};
    vecs[12] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, D0,    2'd0, 2'd1};
    vecs[13] = '{1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, D1,    2'd1, 2'd2};
    vecs[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, D1,    2'd1, 2'd2};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, D1,    2'd1, 2'd2};
    vecs[16] = '{1'b0, 4'b1010, 1'b0, 4'b1000, 1'b1, D3,    2'd3, 2'd0};
    vecs[17] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, D3,    2'd3, 2'd0};
    vecs[18] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b0, 21'd0, 2'd0, 2'd0};
    vecs[19] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1, D1,    2'd1, 2'd2};

    #1;
    for (int i = 0; i < 20; i++) begin
      sys_rst  = vecs[i].rst;
      s_valid  = vecs[i].valid;
      s_id_len = {D3, D2, D1, D0};
      m_ready  = vecs[i].mrdy;
      #2;
      check($sformatf("v%0d_ready", i), 64'(s_ready), 64'(vecs[i].exp_ready));
      @(posedge sys_clk);
      #1;
      check($sformatf("v%0d_valid", i), 64'(m_valid), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d_data", i), 64'(m_id_len), 64'(vecs[i].exp_data));
      check($sformatf("v%0d_src", i), 64'(m_src), 64'(vecs[i].exp_src));
      check($sformatf("v%0d_rr", i), 64'(dut.rr_ptr), 64'(vecs[i].exp_rr));
      check($sformatf("v%0d_drop", i), 64'(drop_cnt), 64'd0);
    end

    // ---------------- zero-length request from requester 1 ----------------
    sys_rst = 1'b1;
    s_valid = '0;
    m_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst  = 1'b0;
    s_valid  = 4'b0010;
    s_id_len = {42'd0, 11'd0, 10'd7, 21'd0};
    #2;
    check("drop_a_ready", 64'(s_ready), 64'(4'b0010));
    @(posedge sys_clk);
    #1;
    check("drop_a_rr", 64'(dut.rr_ptr), 64'd2);
`ifdef POOL_ARB_ZERO_LEN_DROP_EN
    check("drop_a_valid", 64'(m_valid), 64'd0);
    check("drop_a_cnt", 64'(drop_cnt), 64'd1);
`else
    check("drop_a_valid", 64'(m_valid), 64'd1);
    check("drop_a_data", 64'(m_id_len), 64'({11'd0, 10'd7}));
    check("drop_a_src", 64'(m_src), 64'd1);
    check("drop_a_cnt", 64'(drop_cnt), 64'd0);
`endif
    s_id_len = {42'd0, 11'd4, 10'd8, 21'd0};
    #2;
    check("drop_b_ready", 64'(s_ready), 64'(4'b0010));
    @(posedge sys_clk);
    #1;
    check("drop_b_valid", 64'(m_valid), 64'd1);
    check("drop_b_data", 64'(m_id_len), 64'({11'd4, 10'd8}));
    check("drop_b_src", 64'(m_src), 64'd1);
`ifdef POOL_ARB_ZERO_LEN_DROP_EN
    check("drop_b_cnt", 64'(drop_cnt), 64'd1);
`else
    check("drop_b_cnt", 64'(drop_cnt), 64'd0);
`endif

    // ---------------- requester 3 stream, random backpressure ----------------
    sys_rst = 1'b1;
    s_valid = '0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    sent    = 0;
    rcvd    = 0;
    cyc     = 0;
    while (rcvd < 1000 && cyc < 6000) begin
      s_valid  = (sent < 1000) ? 4'b1000 : 4'b0000;
      s_id_len = {stream_pay(sent), 63'd0};
      m_ready  = ($urandom_range(0, 3) != 0);
      #2;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 64'd1, 64'd0);
        end else begin
          got = exp_q.pop_front();
          check("stream_data", 64'({m_src, m_id_len}), 64'({2'd3, got}));
        end
        rcvd++;
      end
      if (s_ready[3]) begin
        exp_q.push_back(stream_pay(sent));
        sent++;
      end
      @(posedge sys_clk);
      #1;
      cyc++;
    end
    check("stream_count", 64'(rcvd), 64'd1000);
    check("stream_leftover", 64'(exp_q.size()), 64'd0);

    s_valid = '0;
    m_ready = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
